// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : key_debouncer
// Brief    : N-channel key synchroniser + debouncer producing clean levels and
//            single-cycle press/release pulses. Define KEY_LONG_PRESS_EN to
//            add the LONG_CYCLES parameter and the key_long pulse output.
// Revision : 1.0 - initial release
// ============================================================================
module key_debouncer #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int KEY_ACTIVE_LOW  = 0
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter int LONG_CYCLES     = 4000000
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic [N_KEYS-1:0] key_long
`endif
);

    localparam logic [CNT_W-1:0] c_DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`endif
    // Pin level that means "not pressed"; the synchroniser resets to it.
    localparam logic c_PIN_IDLE = (KEY_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] w_key;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= {N_KEYS{c_PIN_IDLE}};
            r_sync2 <= {N_KEYS{c_PIN_IDLE}};
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_press;
        logic             r_release;
`ifdef KEY_LONG_PRESS_EN
        logic             r_long;
        logic             r_long_done;
`endif

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_state     <= ST_IDLE;
                r_cnt       <= '0;
                r_level     <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
                r_long      <= 1'b0;
                r_long_done <= 1'b0;
`endif
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
                r_long    <= 1'b0;
`endif
                case (r_state)
                    ST_IDLE: begin
                        if (w_key[i]) begin
                            r_state <= ST_PRESS_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!w_key[i]) begin
                            r_state <= ST_IDLE;
                        end else if (r_cnt == c_DB_LAST) begin
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_key[i]) begin
                            r_state     <= ST_RELEASE_WAIT;
                            r_cnt       <= '0;
`ifdef KEY_LONG_PRESS_EN
                            r_long_done <= 1'b0;
                        end else if (r_cnt == c_LONG_LAST) begin
                            // Counter parks at the limit; the flag limits it to one pulse per hold.
                            if (!r_long_done) begin
                                r_long      <= 1'b1;
                                r_long_done <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
`endif
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (w_key[i]) begin
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_DB_LAST) begin
                            r_state   <= ST_IDLE;
                            r_cnt     <= '0;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign key_level[i]   = r_level;
        assign key_press[i]   = r_press;
        assign key_release[i] = r_release;
`ifdef KEY_LONG_PRESS_EN
        assign key_long[i]    = r_long;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debouncer
// Brief    : Scoreboard bench for key_debouncer; one active-high and one
//            active-low instance driven with complementary pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debouncer;

    localparam int N  = 2;
    localparam int D  = 4;
    localparam int CW = 5;
    localparam int LC = 10;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
    } exp_t;

    logic         clock  = 1'b0;
    logic         reset  = 1'b1;
    logic [N-1:0] key_in = '0;
    logic [N-1:0] key_in_n;
    logic [N-1:0] lvl_h, prs_h, rel_h, lng_h;
    logic [N-1:0] lvl_l, prs_l, rel_l, lng_l;

    assign key_in_n = ~key_in;

    always #5 clock = ~clock;

    key_debouncer #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .KEY_ACTIVE_LOW(0)
`ifdef KEY_LONG_PRESS_EN
        , .LONG_CYCLES(LC)
`endif
    ) dut_hi (
        .clock(clock), .reset(reset), .key_in(key_in),
        .key_level(lvl_h), .key_press(prs_h), .key_release(rel_h)
`ifdef KEY_LONG_PRESS_EN
        , .key_long(lng_h)
`endif
    );

    key_debouncer #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .KEY_ACTIVE_LOW(1)
`ifdef KEY_LONG_PRESS_EN
        , .LONG_CYCLES(LC)
`endif
    ) dut_lo (
        .clock(clock), .reset(reset), .key_in(key_in_n),
        .key_level(lvl_l), .key_press(prs_l), .key_release(rel_l)
`ifdef KEY_LONG_PRESS_EN
        , .key_long(lng_l)
`endif
    );

`ifndef KEY_LONG_PRESS_EN
    assign lng_h = '0;
    assign lng_l = '0;
`endif

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %b required %b at %0t", nm, act, req, $time);
    endtask

    // Reference model: key_in delayed two edges, then a change is accepted once
    // the sample has disagreed with the level on D+1 consecutive edges.
    logic m_sync1[N], m_sync2[N], m_level[N], m_prev_s[N];
    int   m_run[N], m_hold[N];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sync1[i] = 1'b0; m_sync2[i] = 1'b0; m_level[i] = 1'b0;
            m_prev_s[i] = 1'b0; m_run[i] = 0; m_hold[i] = 0;
        end
    endtask

    task automatic model_step(output exp_t e);
        logic s;
        e = '0;
        for (int i = 0; i < N; i++) begin
            s = m_sync2[i];
            m_sync2[i] = m_sync1[i];
            m_sync1[i] = key_in[i];
            // Long hold: edges with the key down, already accepted, and down on the previous edge too.
            if (m_level[i] && s && m_prev_s[i]) begin
                m_hold[i]++;
                if (m_hold[i] == LC) e.lng[i] = 1'b1;
            end else begin
                m_hold[i] = 0;
            end
            if (s != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == D + 1) begin
                    m_level[i] = s;
                    if (s) e.prs[i] = 1'b1;
                    else   e.rel[i] = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            e.lvl[i]    = m_level[i];
            m_prev_s[i] = s;
        end
`ifndef KEY_LONG_PRESS_EN
        e.lng = '0;
`endif
    endtask

    task automatic cycle(input logic [N-1:0] k, input logic r);
        exp_t e;
        logic was_rst;
        @(negedge clock);
        was_rst = reset;
        key_in  = k;
        reset   = r;
        if (r && !was_rst) begin
            #1;
            chk("async_rst_lvl", lvl_h | lvl_l, '0);
            chk("async_rst_pulse", prs_h | prs_l | rel_h | rel_l | lng_h | lng_l, '0);
        end
        @(posedge clock);
        if (reset) begin
            model_reset();
            e = '0;
        end else begin
            model_step(e);
        end
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [N-1:0] k, input int n);
        for (int c = 0; c < n; c++) cycle(k, 1'b0);
    endtask

    // Monitor: every edge the DUTs present a full output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("level_hi",   lvl_h, e.lvl);
                chk("press_hi",   prs_h, e.prs);
                chk("release_hi", rel_h, e.rel);
                chk("level_lo",   lvl_l, e.lvl);
                chk("press_lo",   prs_l, e.prs);
                chk("release_lo", rel_l, e.rel);
`ifdef KEY_LONG_PRESS_EN
                chk("long_hi", lng_h, e.lng);
                chk("long_lo", lng_l, e.lng);
`endif
            end
        end
    end

    initial begin
        logic [N-1:0] k;
        int           rem[N];
        int           guard;

        model_reset();
        for (int c = 0; c < 3; c++) cycle(2'b00, 1'b1);
        hold(2'b00, 4);

        // Clean press then release with a short glitch high.
        hold(2'b01, 12);
        hold(2'b00, 2); hold(2'b01, 2); hold(2'b00, 10);

        // Bounce on the way in.
        hold(2'b01, 3); hold(2'b00, 1); hold(2'b01, 12);
        hold(2'b00, 10);

        // Reset during PRESS_WAIT with the key still held.
        hold(2'b01, 4);
        cycle(2'b01, 1'b1); cycle(2'b01, 1'b1);
        hold(2'b01, 12);
        // Reset while the level is high.
        cycle(2'b01, 1'b1);
        hold(2'b00, 8);

        // Both channels together, then a long hold.
        hold(2'b11, 12); hold(2'b00, 10);
        hold(2'b10, 30); hold(2'b00, 10);
        // Bounce back into PRESSED restarts the long count.
        hold(2'b01, 14); hold(2'b00, 2); hold(2'b01, 16); hold(2'b00, 10);

        // Randomised segments of varying lengths per channel.
        k = '0;
        for (int i = 0; i < N; i++) rem[i] = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    k[i]   = ~k[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 25)
                                                         : $urandom_range(1, 7);
                end
            end
            cycle(k, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        hold(2'b00, 12);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clock);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: actual %0d entries left required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Input-side counterpart to the board's LED drivers: conditions N raw pushbutton/switch inputs into clean, debounced levels and single-cycle press/release events.
- Consumed by pattern/mode logic, e.g. step, pause or reverse control for LED sequencers.
- Sits directly behind the top-level key pins, in the same single clock domain as the LED logic.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change; must be >= 2.
- CNT_W, 20, width of each per-channel counter; must hold DEBOUNCE_CYCLES-1, and LONG_CYCLES-1 when the optional feature is on.
- KEY_ACTIVE_LOW, 0, when 1 the raw input is inverted after synchronisation (pressed = 0 on pin).
- LONG_CYCLES, 4000000, hold time for a long-press event (optional feature only).

Ports:
- clock, input, 1, system clock (already single-ended/buffered).
- reset, input, 1, asynchronous, active-high; clears all state.
- key_in, input, N_KEYS, raw asynchronous key pins.
- key_level, output, N_KEYS, debounced pressed state, 1 = pressed.
- key_press, output, N_KEYS, 1-cycle pulse on accepted press.
- key_release, output, N_KEYS, 1-cycle pulse on accepted release.
- key_long, output, N_KEYS, 1-cycle long-press pulse (present only with KEY_LONG_PRESS_EN).

Behaviour:
- Reset: reset is asynchronous and active-high.
  - While reset is asserted: synchronisers cleared to "not pressed"; all FSMs go to IDLE; counters = 0.
  - key_level, key_press, key_release and key_long = 0.
  - Deassertion takes effect on the next clock edge.
- Synchroniser: per channel, 2-flop synchroniser, then optional inversion; the result is s[i].
- Per-channel FSM states:
  - IDLE (level 0):
    - s=1 → PRESS_WAIT, cnt=0.
  - PRESS_WAIT (level 0):
    - s=0 → IDLE.
    - s=1 and cnt==DEBOUNCE_CYCLES-1 → PRESSED; assert key_press for 1 cycle; key_level=1.
    - otherwise cnt++.
  - PRESSED (level 1):
    - s=0 → RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT (level 1):
    - s=1 → PRESSED.
    - s=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE; assert key_release for 1 cycle; key_level=0.
    - otherwise cnt++.
- Latency: for a clean input step sampled at edge E, key_press/key_level rise at edge E+2+DEBOUNCE_CYCLES. Release latency is identical.
- Glitch rejection: any bounce shorter than DEBOUNCE_CYCLES returns the FSM to its stable state with no pulses. The counter restarts from 0 on the next qualifying edge.
- Outputs are registered; key_press and key_release are never high together and never high for 2 consecutive cycles on one channel.
- Channels are fully independent; simultaneous presses on several channels produce simultaneous pulses.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1 in WAIT states. No wrap is possible.
- Reset mid-debounce: the channel returns to IDLE and no pulse is emitted. A key held through reset re-qualifies from IDLE and then emits key_press.

Optional Feature:
- KEY_LONG_PRESS_EN defined:
  - In PRESSED, cnt counts while s=1.
  - When cnt reaches LONG_CYCLES-1, key_long pulses for 1 cycle; cnt then holds, giving one pulse per hold.
  - cnt is cleared on leaving PRESSED. A bounce back to PRESSED from RELEASE_WAIT restarts the long count.
  - key_press is unaffected.
- KEY_LONG_PRESS_EN undefined: no key_long port, no long-count logic; PRESSED does not count.

Test Plan:
- Bench: N_KEYS=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
- Clean press: key_in[0] 0→1 held → key_press[0]=1 for exactly 1 cycle, 6 cycles after the first sampling edge; key_level[0]=1 thereafter; key_press[1]=0.
- Bounce: key_in[0] toggles high for 3 cycles, low for 1, then stays high → exactly one key_press, 6 cycles after the final rising edge.
- Release: from pressed, key_in[0] goes low with a 2-cycle glitch high → exactly one key_release once low is stable for 4 cycles; key_level[0]=0.
- Reset mid-debounce: press, assert reset at cycle 2 of PRESS_WAIT → all outputs 0 immediately (async); after release of reset with key still held → key_press 6 cycles later.
- Both channels: press both in the same cycle → both key_press bits high in the same cycle; KEY_ACTIVE_LOW=1 run: key_in 1→0 gives the same pulses.
- KEY_LONG_PRESS_EN: hold key 30 cycles → one key_press, then exactly one key_long 10 cycles after entering PRESSED; none without the macro.
